// File: rtl/axil_master_seq.sv
// axil_master_seq
// Turns single commands into one AXI4-Lite read or write transaction, then
// reports completion with a one-cycle response pulse.
//
// Ports
//   clk, reset                 single clock, synchronous active-high reset
//   cmd_valid/cmd_ready        command handshake (cmd_ready high only when idle)
//   cmd_we, cmd_addr,
//   cmd_wdata, cmd_wstrb       command contents, latched on acceptance
//   rsp_valid                  one-cycle completion pulse
//   rsp_rdata                  read data (0 after a write or an abort)
//   rsp_err                    timeout abort flag, valid with rsp_valid
//   aw*, w*, b*                AXI4-Lite write channels
//   ar*, r*                    AXI4-Lite read channels
//
// Build option
//   AXIL_SEQ_TIMEOUT_EN        when defined, an 8-bit wait counter aborts any
//                              transaction stuck for 255 cycles in one state.
//                              When undefined, rsp_err is tied low and the
//                              block waits indefinitely.

module axil_master_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_DATA,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic accept;
  logic aw_ok;
  logic w_ok;
  logic timeout;

  assign accept = (state == IDLE) && cmd_valid && cmd_ready;

  // A write channel is finished once its valid has already dropped or its
  // handshake is happening this cycle; AW and W may finish in any order.
  assign aw_ok = !awvalid || awready;
  assign w_ok  = !wvalid  || wready;

`ifdef AXIL_SEQ_TIMEOUT_EN
  logic [7:0] to_cnt;

  assign timeout = (to_cnt == 8'hFF);

  // Counter restarts on every state change and only runs while waiting on
  // the AXI slave; it never wraps because reaching 255 forces a state change.
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt <= 8'h00;
    end else if (state_next != state) begin
      to_cnt <= 8'h00;
    end else if (state inside {WR_REQ, WR_RESP, RD_REQ, RD_DATA}) begin
      to_cnt <= to_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_err <= 1'b0;
    end else begin
      rsp_err <= timeout && (state_next == DONE);
    end
  end
`else
  assign timeout = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = cmd_we ? WR_REQ : RD_REQ;
        end
      end
      WR_REQ: begin
        if (timeout) begin
          state_next = DONE;
        end else if (aw_ok && w_ok) begin
          state_next = WR_RESP;
        end
      end
      WR_RESP: begin
        if (timeout || bvalid) begin
          state_next = DONE;
        end
      end
      RD_REQ: begin
        if (timeout) begin
          state_next = DONE;
        end else if (arready) begin
          state_next = RD_DATA;
        end
      end
      RD_DATA: begin
        if (timeout || rvalid) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // All interface outputs are registered. Readys and the response pulse are
  // decoded from the state being entered, so they line up with that state.
  // Valids rise on acceptance and fall only after their own handshake or on
  // an abort.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      awaddr    <= 32'h0;
      awvalid   <= 1'b0;
      wdata     <= 32'h0;
      wstrb     <= 4'h0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      araddr    <= 32'h0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
    end else begin
      cmd_ready <= (state_next == IDLE);
      rsp_valid <= (state_next == DONE);
      bready    <= (state_next == WR_RESP);
      rready    <= (state_next == RD_DATA);

      if (accept && cmd_we) begin
        awaddr  <= cmd_addr;
        wdata   <= cmd_wdata;
        wstrb   <= cmd_wstrb;
        awvalid <= 1'b1;
        wvalid  <= 1'b1;
      end else begin
        if (awready || timeout) begin
          awvalid <= 1'b0;
        end
        if (wready || timeout) begin
          wvalid <= 1'b0;
        end
      end

      if (accept && !cmd_we) begin
        araddr  <= cmd_addr;
        arvalid <= 1'b1;
      end else if (arready || timeout) begin
        arvalid <= 1'b0;
      end

      // Only a successful read returns data; writes and aborts report 0.
      if (state_next == DONE) begin
        rsp_rdata <= ((state == RD_DATA) && !timeout) ? rdata : 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_axil_master_seq.sv
// Testbench for axil_master_seq: drives commands, emulates an AXI4-Lite slave
// with configurable per-channel ready/response delays, and compares what it
// observes against latencies and beat contents derived from the transaction
// rules.

module tb_axil_master_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_addr = 32'h0;
  logic [31:0] cmd_wdata = 32'h0;
  logic [3:0]  cmd_wstrb = 4'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready = 1'b0;
  logic        bvalid = 1'b0;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic        rvalid = 1'b0;
  logic        rready;

  int tests_run = 0;
  int tests_failed = 0;

  // Slave behaviour: cycles each valid/ready is seen before the slave answers.
  int          cfg_da, cfg_dw, cfg_db, cfg_dar, cfg_dr;
  logic [31:0] cfg_rdata;
  logic        cfg_hold = 1'b0;

  // Observations of the last transaction (cycle numbers relative to its start).
  int          acc_cyc, pulse_cyc, pulse_cnt, accepts;
  int          aw_beats, w_beats, ar_beats, aw_drop, w_drop;
  logic        drop_viol, obs_err, ready_after;
  logic [31:0] obs_awaddr, obs_wdata, obs_araddr, obs_rdata, rdata_after;
  logic [3:0]  obs_wstrb;

  logic [139:0] all_outs;
  assign all_outs = {cmd_ready, rsp_valid, rsp_rdata, rsp_err, awaddr, awvalid,
                     wdata, wstrb, wvalid, bready, araddr, arvalid, rready};

  always #5 clk = ~clk;

  axil_master_seq dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_wstrb (cmd_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .awaddr    (awaddr),
    .awvalid   (awvalid),
    .awready   (awready),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .wvalid    (wvalid),
    .wready    (wready),
    .bvalid    (bvalid),
    .bready    (bready),
    .araddr    (araddr),
    .arvalid   (arvalid),
    .arready   (arready),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .rready    (rready)
  );

  // Runs one command through the DUT, one iteration per cycle at the falling
  // edge: observe registered outputs, then set inputs for the next rising edge.
  // Stops one cycle after the response pulse or after max_cycles.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int max_cycles);
    logic prev_aw, prev_w, prev_ar, prev_aw_hs, prev_w_hs, prev_ar_hs;
    logic aw_hs, w_hs, ar_hs;
    int   aw_seen, w_seen, b_seen, ar_seen, r_seen;
    prev_aw = 0; prev_w = 0; prev_ar = 0;
    prev_aw_hs = 0; prev_w_hs = 0; prev_ar_hs = 0;
    aw_seen = 0; w_seen = 0; b_seen = 0; ar_seen = 0; r_seen = 0;
    acc_cyc = -1; pulse_cyc = -1; pulse_cnt = 0; accepts = 0;
    aw_beats = 0; w_beats = 0; ar_beats = 0; aw_drop = -1; w_drop = -1;
    drop_viol = 0; obs_err = 0; ready_after = 0;
    obs_awaddr = 0; obs_wdata = 0; obs_wstrb = 0; obs_araddr = 0;
    obs_rdata = 0; rdata_after = 0;
    cmd_we = we; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    for (int k = 0; k < max_cycles; k++) begin
      if (pulse_cyc >= 0) begin
        if (rsp_valid) pulse_cnt++;
        ready_after = cmd_ready;
        rdata_after = rsp_rdata;
        break;
      end
      if (prev_aw && !prev_aw_hs && !awvalid) drop_viol = 1;
      if (prev_w  && !prev_w_hs  && !wvalid)  drop_viol = 1;
      if (prev_ar && !prev_ar_hs && !arvalid) drop_viol = 1;
      if (prev_aw && !awvalid && aw_drop < 0) aw_drop = k;
      if (prev_w  && !wvalid  && w_drop  < 0) w_drop  = k;

      cmd_valid = (acc_cyc < 0) || cfg_hold;
      if (cmd_valid && cmd_ready) begin
        accepts++;
        if (acc_cyc < 0) acc_cyc = k;
      end else if (acc_cyc >= 0) begin
        cmd_we = $urandom_range(0, 1);
        cmd_addr = $urandom;
        cmd_wdata = $urandom;
        cmd_wstrb = 4'($urandom);
      end

      awready = awvalid && (aw_seen >= cfg_da);
      aw_hs = awvalid && awready;
      if (aw_hs) begin aw_beats++; obs_awaddr = awaddr; end
      if (awvalid) aw_seen++;

      wready = wvalid && (w_seen >= cfg_dw);
      w_hs = wvalid && wready;
      if (w_hs) begin w_beats++; obs_wdata = wdata; obs_wstrb = wstrb; end
      if (wvalid) w_seen++;

      bvalid = bready && (b_seen >= cfg_db);
      if (bready) b_seen++;

      arready = arvalid && (ar_seen >= cfg_dar);
      ar_hs = arvalid && arready;
      if (ar_hs) begin ar_beats++; obs_araddr = araddr; end
      if (arvalid) ar_seen++;

      rvalid = rready && (r_seen >= cfg_dr);
      rdata = rvalid ? cfg_rdata : $urandom;
      if (rready) r_seen++;

      if (rsp_valid) begin
        pulse_cnt++;
        pulse_cyc = k;
        obs_rdata = rsp_rdata;
        obs_err = rsp_err;
      end

      prev_aw = awvalid; prev_w = wvalid; prev_ar = arvalid;
      prev_aw_hs = aw_hs; prev_w_hs = w_hs; prev_ar_hs = ar_hs;
      @(negedge clk);
    end
    cmd_valid = 0; awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (all_outs !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got %h required 0", all_outs);
    end
    reset = 0;
    @(negedge clk);
    tests_run++;
    if (cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_release_ready: got %b required 1", cmd_ready);
    end
  endtask

  task automatic test_basic_write();
    cfg_da = 0; cfg_dw = 0; cfg_db = 0; cfg_dar = 0; cfg_dr = 0; cfg_rdata = 0;
    run_txn(1'b1, 32'h10, 32'h12345678, 4'hF, 50);
    tests_run++;
    if (acc_cyc < 0 || pulse_cyc - acc_cyc != 3) begin
      tests_failed++;
      $display("[TB] FAIL wr_latency: got acc=%0d pulse=%0d required distance 3", acc_cyc, pulse_cyc);
    end
    tests_run++;
    if (aw_beats != 1 || obs_awaddr !== 32'h10) begin
      tests_failed++;
      $display("[TB] FAIL wr_aw_beat: got %0d beats addr %h required 1 beat addr 10", aw_beats, obs_awaddr);
    end
    tests_run++;
    if (w_beats != 1 || obs_wdata !== 32'h12345678 || obs_wstrb !== 4'hF) begin
      tests_failed++;
      $display("[TB] FAIL wr_w_beat: got %0d beats %h/%h required 1 beat 12345678/f", w_beats, obs_wdata, obs_wstrb);
    end
    tests_run++;
    if (pulse_cnt != 1 || obs_err !== 1'b0 || obs_rdata !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL wr_response: got pulses=%0d err=%b rdata=%h required 1/0/0", pulse_cnt, obs_err, obs_rdata);
    end
    tests_run++;
    if (ar_beats != 0) begin
      tests_failed++;
      $display("[TB] FAIL wr_no_ar: got %0d ar beats required 0", ar_beats);
    end
  endtask

  task automatic test_write_order();
    cfg_da = 3; cfg_dw = 0; cfg_db = 1;
    run_txn(1'b1, 32'h1234, 32'hA5A5_0F0F, 4'h6, 50);
    tests_run++;
    if (w_drop < 0 || aw_drop - w_drop != 3) begin
      tests_failed++;
      $display("[TB] FAIL order_drop: got w_drop=%0d aw_drop=%0d required aw 3 cycles after w", w_drop, aw_drop);
    end
    tests_run++;
    if (aw_beats != 1 || w_beats != 1) begin
      tests_failed++;
      $display("[TB] FAIL order_beats: got aw=%0d w=%0d required 1/1", aw_beats, w_beats);
    end
    tests_run++;
    if (drop_viol !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL order_valid_hold: got early drop=%b required 0", drop_viol);
    end
    tests_run++;
    if (acc_cyc < 0 || pulse_cyc - acc_cyc != 7) begin
      tests_failed++;
      $display("[TB] FAIL order_latency: got acc=%0d pulse=%0d required distance 7", acc_cyc, pulse_cyc);
    end
  endtask

  task automatic test_read();
    cfg_dar = 2; cfg_dr = 1; cfg_rdata = 32'hDEADBEEF;
    run_txn(1'b0, 32'h20, 32'h0, 4'h0, 50);
    tests_run++;
    if (ar_beats != 1 || obs_araddr !== 32'h20) begin
      tests_failed++;
      $display("[TB] FAIL rd_ar_beat: got %0d beats addr %h required 1 beat addr 20", ar_beats, obs_araddr);
    end
    tests_run++;
    if (pulse_cnt != 1 || obs_rdata !== 32'hDEADBEEF || obs_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rd_response: got pulses=%0d rdata=%h err=%b required 1/deadbeef/0", pulse_cnt, obs_rdata, obs_err);
    end
    tests_run++;
    if (acc_cyc < 0 || pulse_cyc - acc_cyc != 6) begin
      tests_failed++;
      $display("[TB] FAIL rd_latency: got acc=%0d pulse=%0d required distance 6", acc_cyc, pulse_cyc);
    end
    tests_run++;
    if (rdata_after !== 32'hDEADBEEF || ready_after !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL rd_hold: got rdata=%h ready=%b required deadbeef/1", rdata_after, ready_after);
    end
    tests_run++;
    if (aw_beats != 0 || w_beats != 0) begin
      tests_failed++;
      $display("[TB] FAIL rd_no_write: got aw=%0d w=%0d required 0/0", aw_beats, w_beats);
    end
  endtask

  task automatic test_reset_mid_read();
    cfg_dar = 0; cfg_dr = 100000;
    run_txn(1'b0, 32'h40, 32'h0, 4'h0, 4);
    tests_run++;
    if (rready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL rst_reach_rd_data: got rready=%b required 1", rready);
    end
    reset = 1;
    @(negedge clk);
    tests_run++;
    if (all_outs !== '0) begin
      tests_failed++;
      $display("[TB] FAIL rst_mid_read_outputs: got %h required 0", all_outs);
    end
    reset = 0;
    @(negedge clk);
    tests_run++;
    if (cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL rst_mid_read_ready: got %b required 1", cmd_ready);
    end
  endtask

  task automatic test_hold_cmd();
    cfg_hold = 1; cfg_da = 1; cfg_dw = 2; cfg_db = 1;
    run_txn(1'b1, 32'h88, 32'h5555_AAAA, 4'h3, 50);
    cfg_hold = 0;
    tests_run++;
    if (accepts != 1) begin
      tests_failed++;
      $display("[TB] FAIL hold_accepts: got %0d required 1", accepts);
    end
    tests_run++;
    if (ready_after !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL hold_ready_after: got %b required 1", ready_after);
    end
    tests_run++;
    if (acc_cyc < 0 || pulse_cyc - acc_cyc != 6 || pulse_cnt != 1) begin
      tests_failed++;
      $display("[TB] FAIL hold_latency: got acc=%0d pulse=%0d n=%0d required distance 6, 1 pulse", acc_cyc, pulse_cyc, pulse_cnt);
    end
    tests_run++;
    if (aw_beats != 1 || w_beats != 1 || obs_awaddr !== 32'h88) begin
      tests_failed++;
      $display("[TB] FAIL hold_beats: got aw=%0d w=%0d addr=%h required 1/1/88", aw_beats, w_beats, obs_awaddr);
    end
  endtask

  // Consecutive random commands issued back-to-back; expectations come from
  // the channel delays: a write finishes 3 cycles plus the slower of AW/W plus
  // the B delay after acceptance, a read 3 cycles plus AR and R delays.
  task automatic test_back_to_back();
    logic        we;
    logic [31:0] a, d, exp_rdata;
    logic [3:0]  s;
    int          exp_lat;
    for (int n = 0; n < 24; n++) begin
      we = 1'($urandom_range(0, 1));
      a = $urandom; d = $urandom; s = 4'($urandom);
      cfg_da = $urandom_range(0, 3); cfg_dw = $urandom_range(0, 3);
      cfg_db = $urandom_range(0, 3); cfg_dar = $urandom_range(0, 3);
      cfg_dr = $urandom_range(0, 3); cfg_rdata = $urandom;
      run_txn(we, a, d, s, 60);
      exp_lat = we ? 3 + ((cfg_da > cfg_dw) ? cfg_da : cfg_dw) + cfg_db : 3 + cfg_dar + cfg_dr;
      exp_rdata = we ? 32'h0 : cfg_rdata;
      tests_run++;
      if (acc_cyc < 0 || pulse_cyc < 0 || pulse_cyc - acc_cyc != exp_lat || pulse_cnt != 1) begin
        tests_failed++;
        $display("[TB] FAIL rand%0d_latency: got acc=%0d pulse=%0d n=%0d required distance %0d, 1 pulse",
                 n, acc_cyc, pulse_cyc, pulse_cnt, exp_lat);
      end
      tests_run++;
      if (aw_beats != (we ? 1 : 0) || w_beats != (we ? 1 : 0) || ar_beats != (we ? 0 : 1)) begin
        tests_failed++;
        $display("[TB] FAIL rand%0d_beats: got aw=%0d w=%0d ar=%0d required we=%b", n, aw_beats, w_beats, ar_beats, we);
      end
      tests_run++;
      if ((we ? obs_awaddr : obs_araddr) !== a) begin
        tests_failed++;
        $display("[TB] FAIL rand%0d_addr: got %h required %h", n, we ? obs_awaddr : obs_araddr, a);
      end
      if (we) begin
        tests_run++;
        if (obs_wdata !== d || obs_wstrb !== s) begin
          tests_failed++;
          $display("[TB] FAIL rand%0d_wdata: got %h/%h required %h/%h", n, obs_wdata, obs_wstrb, d, s);
        end
      end
      tests_run++;
      if (obs_rdata !== exp_rdata || rdata_after !== exp_rdata || obs_err !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL rand%0d_rsp: got rdata=%h after=%h err=%b required %h/%h/0",
                 n, obs_rdata, rdata_after, obs_err, exp_rdata, exp_rdata);
      end
      tests_run++;
      if (drop_viol !== 1'b0 || accepts != 1) begin
        tests_failed++;
        $display("[TB] FAIL rand%0d_protocol: got early_drop=%b accepts=%0d required 0/1", n, drop_viol, accepts);
      end
    end
  endtask

  task automatic test_timeout();
    cfg_da = 100000; cfg_dw = 0; cfg_db = 0;
`ifdef AXIL_SEQ_TIMEOUT_EN
    run_txn(1'b1, 32'h99, 32'h1, 4'hF, 400);
    // Abort lands about 255 counted cycles into WR_REQ; allow one cycle of
    // edge-counting slack either way around 257.
    tests_run++;
    if (acc_cyc < 0 || pulse_cyc < 0 || pulse_cyc - acc_cyc < 256 || pulse_cyc - acc_cyc > 258) begin
      tests_failed++;
      $display("[TB] FAIL to_latency: got acc=%0d pulse=%0d required distance 256..258", acc_cyc, pulse_cyc);
    end
    tests_run++;
    if (obs_err !== 1'b1 || obs_rdata !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL to_response: got err=%b rdata=%h required 1/0", obs_err, obs_rdata);
    end
    tests_run++;
    if ({awvalid, wvalid, bready} !== 3'b000 || aw_beats != 0) begin
      tests_failed++;
      $display("[TB] FAIL to_abort_outputs: got aw=%b w=%b b=%b beats=%0d required 0/0/0/0", awvalid, wvalid, bready, aw_beats);
    end
`else
    run_txn(1'b1, 32'h99, 32'h1, 4'hF, 1000);
    tests_run++;
    if (pulse_cyc != -1) begin
      tests_failed++;
      $display("[TB] FAIL wait_no_response: got pulse at %0d required none", pulse_cyc);
    end
    tests_run++;
    if ({awvalid, wvalid} !== 2'b10 || aw_beats != 0) begin
      tests_failed++;
      $display("[TB] FAIL wait_still_pending: got aw=%b w=%b beats=%0d required 1/0/0", awvalid, wvalid, aw_beats);
    end
    reset = 1;
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    tests_run++;
    if (cmd_ready !== 1'b1 || awvalid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL wait_recover: got ready=%b aw=%b required 1/0", cmd_ready, awvalid);
    end
`endif
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_basic_write();
    test_write_order();
    test_read();
    test_reset_mid_read();
    test_hold_cmd();
    test_back_to_back();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/axil_master_seq.md
AXIL_MASTER_SEQ -- requirements
Module: axil_master_seq

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning), clock and reset first:
 - clk  in  1  single clock; all logic on its rising edge
 - reset  in  1  synchronous, active-high reset
 - cmd_valid  in  1  command request
 - cmd_ready  out  1  command accepted when high with cmd_valid
 - cmd_we  in  1  1 = write, 0 = read
 - cmd_addr  in  32  byte address
 - cmd_wdata  in  32  write data
 - cmd_wstrb  in  4  write byte strobes
 - rsp_valid  out  1  one-cycle completion pulse
 - rsp_rdata  out  32  read data, valid with rsp_valid
 - rsp_err  out  1  timeout abort flag, valid with rsp_valid
 - awaddr  out  32  write address
 - awvalid  out  1  write address valid
 - awready  in  1  write address ready
 - wdata  out  32  write data
 - wstrb  out  4  write strobes
 - wvalid  out  1  write data valid
 - wready  in  1  write data ready
 - bvalid  in  1  write response valid
 - bready  out  1  write response ready
 - araddr  out  32  read address
 - arvalid  out  1  read address valid
 - arready  in  1  read address ready
 - rdata  in  32  read data
 - rvalid  in  1  read data valid
 - rready  out  1  read data ready
REQ-002 The block SHALL have one clock, clk, and a synchronous active-high reset, reset.

Function
REQ-003 States SHALL be IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA and DONE.
REQ-004 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a cycle with cmd_valid=1 and cmd_ready=1; cmd_addr, cmd_wdata and cmd_wstrb are latched on that edge.
REQ-005 Accepted write: next state WR_REQ; awvalid=1 and wvalid=1 are registered and visible the cycle after acceptance.
REQ-006 In WR_REQ, awvalid and wvalid SHALL drop independently, each on the cycle after its own valid&ready handshake; same-cycle handshakes and either order SHALL be legal.
REQ-007 When both AW and W handshakes are complete: go to WR_RESP with bready=1, hold until bvalid=1, then drop bready and go to DONE.
REQ-008 Accepted read: go to RD_REQ with arvalid=1; on arready, drop arvalid and go to RD_DATA with rready=1; on rvalid, capture rdata into rsp_rdata, drop rready and go to DONE.
REQ-009 AXI valids SHALL NOT deassert before their handshake, except on reset or timeout abort.
REQ-010 DONE SHALL assert rsp_valid for exactly one cycle, then return to IDLE; responses have no backpressure.
REQ-011 rsp_rdata SHALL hold its last captured value between reads; it is 0 after a write response.
REQ-012 A minimum write takes 4 cycles and a minimum read 4 cycles from acceptance to the rsp_valid pulse.
REQ-013 cmd_valid outside IDLE SHALL be ignored and not queued.

Reset
REQ-014 Reset SHALL take priority over all events, abandon any transaction in flight, and force the following on the next edge: state IDLE; all valids, readys and rsp_* low; all address and data outputs 0; timeout counter 0. cmd_ready=1 the cycle after reset is released.

Configuration
REQ-015 With AXIL_SEQ_TIMEOUT_EN defined, an 8-bit counter SHALL clear on each state entry and increment in WR_REQ, WR_RESP, RD_REQ and RD_DATA. When it reaches 255, all AXI valids and readys drop and the block enters DONE with rsp_err=1 and rsp_rdata=0.
REQ-016 Without AXIL_SEQ_TIMEOUT_EN, no counter SHALL be present, rsp_err SHALL be tied 0, and the block waits indefinitely.

Verification
REQ-017 Write addr 0x10, data 0x12345678, strb 0xF, awready and wready high -> one AW and one W beat with those values; bvalid on the next cycle -> rsp_valid pulse 4 cycles after acceptance, rsp_err=0.
REQ-018 wready 3 cycles before awready -> wvalid drops first, awvalid holds until its handshake; exactly one beat per channel.
REQ-019 Read addr 0x20, arready delayed 2 cycles, rvalid with rdata 0xDEADBEEF -> araddr=0x20, rsp_rdata=0xDEADBEEF on a single rsp_valid pulse.
REQ-020 Reset asserted in RD_DATA -> next cycle all outputs 0 and state IDLE; cmd_ready=1 after release.
REQ-021 With AXIL_SEQ_TIMEOUT_EN defined, awready held 0 -> abort after 255 cycles in WR_REQ, rsp_valid=1 with rsp_err=1; without the macro, still waiting at 1000 cycles.
REQ-022 cmd_valid held high through a whole write -> exactly one command accepted per IDLE visit.
